uart_rx_cmd: RTL and testbench
==============================

Name: uart_rx_cmd

Overview:
- Serial command receiver for the car control path: deserialises 8N1 UART frames from the Bluetooth/serial module pin.
- Presents the last good byte as a held level on data[7:0]; downstream command decoders (LED, motor) compare data against command codes every cycle.
- Also emits per-frame strobes (data_valid, frame_err) and a busy flag for consumers needing edge-style commands.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- CLKS_PER_BIT (localparam) = CLK_FREQ/BAUD, integer division; must be >= 4. HALF_BIT = CLKS_PER_BIT/2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- rx  input  1  asynchronous serial line, idle high.
- data  output  8  last correctly framed byte, held until the next good frame.
- data_valid  output  1  one-cycle pulse when data is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset (async, rst_n low): data=8'h00, data_valid=0, frame_err=0, busy=0. Both sync flops=1, state=IDLE, counters=0. Reset mid-frame abandons the frame; data keeps no partial bits.
- Input sync: rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s only.
- Counters:
  - clk_cnt, width $clog2(CLKS_PER_BIT), wraps to 0 on each bit boundary as below.
  - bit_idx, 3 bits.
- IDLE:
  - rx_s==0 -> START, clk_cnt=0.
- START:
  - clk_cnt increments each cycle.
  - At clk_cnt==HALF_BIT-1: if rx_s==0 -> DATA, clk_cnt=0, bit_idx=0; else glitch -> IDLE, no strobe.
- DATA:
  - At clk_cnt==CLKS_PER_BIT-1: shift_reg[bit_idx]<=rx_s (LSB first), clk_cnt=0.
  - If bit_idx==7 -> STOP, else bit_idx+1.
- STOP:
  - At clk_cnt==CLKS_PER_BIT-1, sample rx_s.
  - If 1: data<=shift_reg, data_valid=1 for exactly the next cycle -> IDLE.
  - If 0: frame_err=1 for one cycle, data unchanged -> BREAK.
- BREAK:
  - Wait for rx_s==1, then -> IDLE.
  - Prevents a held-low line (break) from retriggering frames.
- Strobe timing: data_valid and frame_err are registered and never high simultaneously. data and data_valid change on the same edge.
- Latency: from rx falling edge to data_valid high ≈ 2 (sync) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles (±1).
- Back-to-back frames: a start bit immediately after a stop bit is accepted. The FSM returns to IDLE at mid-stop-bit, which leaves ≥ half a bit of margin.
- busy: combinational decode of state != IDLE, registered state only. It is high in BREAK.
- The shift register is not cleared between frames; every bit is overwritten before use.

Test Plan:
(Bench uses CLK_FREQ=1_000_000, BAUD=100_000, so CLKS_PER_BIT=10.)
- Reset then idle-high line for 200 cycles -> data=0x00, data_valid/frame_err never asserted, busy=0.
- Send frame 0x01 -> data=0x01, exactly one data_valid pulse ~97 cycles after the start edge. Then send 0x02 -> data=0x02, one pulse. Downstream LED model goes on then off.
- Send 0xA5 then 0x3C with no idle gap -> two data_valid pulses, data=0xA5 then 0x3C, no frame_err.
- 3-cycle low glitch on idle rx -> returns to IDLE, busy high ≤6 cycles, no strobes, data unchanged.
- Frame 0x55 with stop bit driven 0, line then held low 50 cycles then high -> one frame_err pulse, data keeps its previous value, busy stays high until rx_s high. A following good 0x33 is received correctly.
- Assert rst_n low mid-way through bit 4 of 0xFF, then release -> all outputs at reset values, no data_valid. The next full frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_cmd.sv
// 8N1 UART command receiver: holds the last good byte on data, with per-frame
// data_valid/frame_err strobes and a busy flag while a frame is in progress.
module uart_rx_cmd #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;

    // Two-flop synchroniser; reset to the idle-high line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: the start bit is confirmed at mid-bit, after which every
    // sample lands one full bit later, i.e. near the middle of each bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state   <= S_START;
                        clk_cnt <= '0;
                    end
                end
                S_START: begin
                    if (clk_cnt == CNT_HALF) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state   <= S_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == CNT_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            data       <= shift_reg;
                            data_valid <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= S_BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                // A line held low after a bad stop bit must not retrigger frames.
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd at 10 clocks per bit: directed scenarios
// plus random frames checked against a queue-based byte model.
module tb_uart_rx_cmd;

    localparam int CPB = 10;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int cmp_count  = 0;
    int fail_count = 0;
    int cyc        = 0;
    int dv_count   = 0;
    int fe_count   = 0;
    int busy_cnt   = 0;
    int last_dv_cyc = 0;
    int start_cyc  = 0;

    logic [7:0] exp_data;
    logic [7:0] exp_q[$];
    logic [7:0] rcv_q[$];

    uart_rx_cmd #(
        .CLK_FREQ(1_000_000),
        .BAUD    (100_000)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_count++;
        assert (obs === exp) else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Observe strobes away from the active edge and log received bytes.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (data_valid) begin
            dv_count++;
            last_dv_cyc = cyc;
            rcv_q.push_back(data);
        end
        if (frame_err) fe_count++;
        if (data_valid || frame_err)
            check_output("strobe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
    end

    task automatic hold_bit(input logic level);
        rx = level;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input logic stop_bit);
        @(negedge clk);
        start_cyc = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        if (stop_bit) begin
            exp_q.push_back(b);
            exp_data = b;
            rx = 1'b1;
            repeat (CPB - 1) @(negedge clk);
        end else begin
            rx = 1'b0;
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic compare_queues(input string tag);
        while (exp_q.size() > 0) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (rcv_q.size() == 0) begin
                check_output({tag, "_missing"}, 32'hFFFF_FFFF, {24'd0, e});
            end else begin
                check_output({tag, "_byte"}, {24'd0, rcv_q.pop_front()}, {24'd0, e});
            end
        end
        check_output({tag, "_extra"}, rcv_q.size(), 32'd0);
        rcv_q.delete();
    endtask

    initial begin
        logic [7:0] rb;
        int gap, dv0, fe0, lat;
        rx       = 1'b1;
        rst_n    = 1'b0;
        exp_data = 8'h00;
        repeat (3) @(negedge clk);
        check_output("reset_data", {24'd0, data}, 32'd0);
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_dv", {31'd0, data_valid}, 32'd0);
        rst_n = 1'b1;

        busy_cnt = 0;
        idle(200);
        check_output("idle_data", {24'd0, data}, 32'd0);
        check_output("idle_dv_count", dv_count, 32'd0);
        check_output("idle_fe_count", fe_count, 32'd0);
        check_output("idle_busy_cnt", busy_cnt, 32'd0);

        apply_stimulus(8'h01, 1'b1);
        idle(5);
        lat = last_dv_cyc - start_cyc;
        check_output("latency_0x01", {31'd0, (lat >= 97 && lat <= 99)}, 32'd1);
        check_output("data_0x01", {24'd0, data}, {24'd0, exp_data});
        check_output("led_on", {31'd0, data == 8'h01}, 32'd1);
        compare_queues("frame01");
        apply_stimulus(8'h02, 1'b1);
        idle(5);
        check_output("data_0x02", {24'd0, data}, {24'd0, exp_data});
        check_output("led_off", {31'd0, data == 8'h01}, 32'd0);
        compare_queues("frame02");

        fe0 = fe_count;
        apply_stimulus(8'hA5, 1'b1);
        apply_stimulus(8'h3C, 1'b1);
        idle(5);
        check_output("b2b_data", {24'd0, data}, {24'd0, exp_data});
        check_output("b2b_no_fe", fe_count, fe0);
        compare_queues("b2b");

        dv0 = dv_count;
        busy_cnt = 0;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        idle(15);
        check_output("glitch_busy_range", {31'd0, (busy_cnt >= 1 && busy_cnt <= 6)}, 32'd1);
        check_output("glitch_busy_end", {31'd0, busy}, 32'd0);
        check_output("glitch_no_dv", dv_count, dv0);
        check_output("glitch_no_fe", fe_count, fe0);
        check_output("glitch_data", {24'd0, data}, {24'd0, exp_data});

        apply_stimulus(8'h55, 1'b0);
        repeat (50) @(negedge clk);
        check_output("break_fe_pulse", fe_count, fe0 + 1);
        check_output("break_busy_held", {31'd0, busy}, 32'd1);
        check_output("break_data_kept", {24'd0, data}, {24'd0, exp_data});
        idle(5);
        check_output("break_busy_release", {31'd0, busy}, 32'd0);
        apply_stimulus(8'h33, 1'b1);
        idle(5);
        check_output("after_break_data", {24'd0, data}, {24'd0, exp_data});
        compare_queues("after_break");

        dv0 = dv_count;
        @(negedge clk);
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        exp_data = 8'h00;
        repeat (3) @(negedge clk);
        check_output("midreset_data", {24'd0, data}, 32'd0);
        check_output("midreset_busy", {31'd0, busy}, 32'd0);
        check_output("midreset_fe", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        idle(CPB * 6);
        check_output("midreset_no_dv", dv_count, dv0);
        apply_stimulus(8'h0F, 1'b1);
        idle(5);
        check_output("post_reset_data", {24'd0, data}, {24'd0, exp_data});
        compare_queues("post_reset");

        for (int n = 0; n < 8; n++) begin
            rb  = 8'($urandom);
            gap = $urandom_range(0, 20);
            apply_stimulus(rb, 1'b1);
            idle(gap);
        end
        idle(5);
        check_output("random_data", {24'd0, data}, {24'd0, exp_data});
        check_output("random_no_fe", fe_count, fe0 + 1);
        compare_queues("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
